// File: rtl/dvi_pkg.sv
// dvi_pkg: TMDS control tokens and channel alignment states shared by the aligner.
package dvi_pkg;
  localparam logic [9:0] CTRL_0 = 10'h354;
  localparam logic [9:0] CTRL_1 = 10'h0AB;
  localparam logic [9:0] CTRL_2 = 10'h154;
  localparam logic [9:0] CTRL_3 = 10'h2AB;
  typedef enum logic [1:0] {IDLE, SEARCH, SLIP, LOCKED} state_t;
  function automatic logic is_ctrl(input logic [9:0] w);
    return w == CTRL_0 || w == CTRL_1 || w == CTRL_2 || w == CTRL_3;
  endfunction
endpackage

// File: rtl/dvi_rx_align_ch.sv
// dvi_rx_align_ch: word alignment for one TMDS channel by hunting for control-token runs.
module dvi_rx_align_ch
  import dvi_pkg::*;
#(
  parameter int WINDOW    = 4096,
  parameter int RUN_LEN   = 8,
  parameter int LOCK_HITS = 4,
  parameter int SLIP_WAIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [9:0] data_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic [3:0] slip_cnt_o
);
  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0] TC = WW'(WINDOW - 1);
  localparam logic [7:0] RL = 8'(RUN_LEN);
  localparam logic [7:0] SW = 8'(SLIP_WAIT - 1);
  localparam logic [3:0] LH = 4'(LOCK_HITS - 1);
  state_t state, state_n;
  logic [WW-1:0] win, win_n;
  logic [7:0] run, run_n, wait_c, wait_n;
  logic [3:0] hits, hits_n, slips, slips_n;
  logic hit, hit_n, miss, miss_n, slip, slip_n;
  logic tc, tok, hit_eff;
  assign tc = win == TC;
  assign tok = is_ctrl(data_i);
  // a run completing in the window's last counted word still scores for that window
  assign hit_eff = hit || run == RL;
  assign bitslip_o = slip;
  assign locked_o = state == LOCKED;
  assign slip_cnt_o = slips;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      win    <= '0;
      run    <= 8'd0;
      wait_c <= 8'd0;
      hits   <= 4'd0;
      slips  <= 4'd0;
      hit    <= 1'b0;
      miss   <= 1'b0;
      slip   <= 1'b0;
    end else begin
      state  <= state_n;
      win    <= win_n;
      run    <= run_n;
      wait_c <= wait_n;
      hits   <= hits_n;
      slips  <= slips_n;
      hit    <= hit_n;
      miss   <= miss_n;
      slip   <= slip_n;
    end
  end
  always_comb begin
    state_n = state;
    win_n   = tc ? '0 : win + 1'b1;
    run_n   = tok ? (run == RL ? run : run + 8'd1) : 8'd0;
    hit_n   = !tc && hit_eff;
    hits_n  = hits;
    miss_n  = miss;
    slips_n = slips;
    wait_n  = 8'd0;
    slip_n  = 1'b0;
    case (state)
      IDLE: begin
        state_n = SEARCH;
        win_n   = '0;
        run_n   = 8'd0;
        hit_n   = 1'b0;
        hits_n  = 4'd0;
        miss_n  = 1'b0;
        slips_n = 4'd0;
      end
      SEARCH: if (tc) begin
        if (!hit_eff) begin
          state_n = SLIP;
          hits_n  = 4'd0;
          slip_n  = 1'b1;
          slips_n = slips == 4'd9 ? 4'd0 : slips + 4'd1;
        end else if (hits == LH) begin
          state_n = LOCKED;
          hits_n  = 4'd0;
          miss_n  = 1'b0;
        end else hits_n = hits + 4'd1;
      end
      SLIP: begin
        win_n   = '0;
        run_n   = 8'd0;
        hit_n   = 1'b0;
        wait_n  = wait_c == SW ? 8'd0 : wait_c + 8'd1;
        state_n = wait_c == SW ? SEARCH : SLIP;
      end
      LOCKED: if (tc) begin
        state_n = hit_eff || !miss ? LOCKED : SEARCH;
        miss_n  = !hit_eff && !miss;
      end
      default: state_n = IDLE;
    endcase
    if (!en_i) begin
      state_n = IDLE;
      win_n   = '0;
      run_n   = 8'd0;
      hit_n   = 1'b0;
      hits_n  = 4'd0;
      miss_n  = 1'b0;
      slips_n = 4'd0;
      wait_n  = 8'd0;
      slip_n  = 1'b0;
    end
  end
endmodule

// File: rtl/dvi_rx_align.sv
// dvi_rx_align: three independent channel aligners plus lock summary and deserializer calibration enable.
module dvi_rx_align
  import dvi_pkg::*;
#(
  parameter int WINDOW    = 4096,
  parameter int RUN_LEN   = 8,
  parameter int LOCK_HITS = 4,
  parameter int SLIP_WAIT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [2:0][9:0] par_data_i,
  output logic [2:0]      bitslip_o,
  output logic [2:0]      locked_o,
  output logic            all_locked_o,
  output logic            cal_en_o,
  output logic [2:0][3:0] slip_cnt_o
);
  for (genvar i = 0; i < 3; i++) begin : g_ch
    dvi_rx_align_ch #(
      .WINDOW(WINDOW), .RUN_LEN(RUN_LEN), .LOCK_HITS(LOCK_HITS), .SLIP_WAIT(SLIP_WAIT)
    ) u_ch (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i(en_i),
      .data_i(par_data_i[i]),
      .bitslip_o(bitslip_o[i]),
      .locked_o(locked_o[i]),
      .slip_cnt_o(slip_cnt_o[i])
    );
  end
  assign all_locked_o = &locked_o;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cal_en_o <= 1'b0;
    else cal_en_o <= en_i && !all_locked_o;
  end
endmodule

// File: tb/tb_dvi_rx_align.sv
// tb_dvi_rx_align: randomized token-run scenarios checked against window-level timing predictions.
module tb_dvi_rx_align;
  localparam int WINDOW = 64, RUN_LEN = 4, LOCK_HITS = 2, SLIP_WAIT = 8;
  localparam int PER = WINDOW + SLIP_WAIT;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0][9:0] par_data = '0;
  logic [2:0] bitslip, locked;
  logic all_locked, cal_en;
  logic [2:0][3:0] slip_cnt;
  logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  int vectors = 0, errors = 0;
  int rs [3] = '{100, 100, 100};
  int rl [3] = '{0, 0, 0};
  int rs2 [3] = '{100, 100, 100};

  dvi_rx_align #(.WINDOW(WINDOW), .RUN_LEN(RUN_LEN), .LOCK_HITS(LOCK_HITS), .SLIP_WAIT(SLIP_WAIT)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .par_data_i(par_data),
    .bitslip_o(bitslip), .locked_o(locked), .all_locked_o(all_locked),
    .cal_en_o(cal_en), .slip_cnt_o(slip_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic is_tok(input logic [9:0] w);
    return w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB;
  endfunction

  function automatic logic [9:0] junk();
    logic [9:0] w;
    do w = 10'($urandom); while (is_tok(w));
    return w;
  endfunction

  function automatic logic [9:0] rtok();
    return toks[$urandom_range(0, 3)];
  endfunction

  // kind: 0 junk, 1 hit run (4..14), 2 two runs of 3, 3 ten x 354, 4 constant 1F0; p = position in window (>=64 during slip)
  task automatic set_ch(input int c, input int kind, input int p);
    logic [9:0] w;
    if (p == 0) begin
      rs[c] = $urandom_range(8, 40);
      rl[c] = $urandom_range(4, 14);
      rs2[c] = rs[c] + 4 + $urandom_range(0, 8);
    end
    case (kind)
      1: w = (p >= rs[c] && p < rs[c] + rl[c]) ? rtok() : junk();
      2: w = ((p >= rs[c] && p < rs[c] + 3) || (p >= rs2[c] && p < rs2[c] + 3)) ? rtok() : junk();
      3: w = (p >= rs[c] && p < rs[c] + 10) ? 10'h354 : junk();
      4: w = 10'h1F0;
      default: w = junk();
    endcase
    par_data[c] = w;
  endtask

  task automatic restart();
    en = 1'b0;
    for (int c = 0; c < 3; c++) par_data[c] = junk();
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    for (int c = 0; c < 3; c++) par_data[c] = 10'h354;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({bitslip, locked, all_locked, cal_en} !== 8'd0 || slip_cnt !== 12'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got bs=%b lk=%b al=%b ce=%b sc=%h exp all zero", i, bitslip, locked, all_locked, cal_en, slip_cnt);
      end
    end
    rst = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_scn1_lock();
    restart();
    for (int t = 0; t < 140; t++) begin
      vectors++;
      if (locked !== (t >= 128 ? 3'b111 : 3'b000) || all_locked !== (t >= 128) || bitslip !== 3'b000 || cal_en !== (t < 129)) begin
        errors++;
        $display("FAIL scn1 t=%0d got lk=%b al=%b bs=%b ce=%b exp lk=%0d bs=0 ce=%0d", t, locked, all_locked, bitslip, cal_en, t >= 128, t < 129);
      end
      for (int c = 0; c < 3; c++) set_ch(c, 3, t % WINDOW);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_scn2_noise();
    int n1;
    logic [2:0][3:0] es;
    restart();
    for (int t = 0; t < 800; t++) begin
      n1 = t < WINDOW ? 0 : ((t - WINDOW) / PER + 1) % 10;
      es = '0;
      es[1] = 4'(n1);
      vectors++;
      if (bitslip !== ((t >= WINDOW && (t - WINDOW) % PER == 0) ? 3'b010 : 3'b000) || slip_cnt !== es
          || locked !== (t >= 128 ? 3'b101 : 3'b000) || all_locked !== 1'b0 || cal_en !== 1'b1) begin
        errors++;
        $display("FAIL scn2 t=%0d got bs=%b sc=%h lk=%b al=%b ce=%b exp sc=%h", t, bitslip, slip_cnt, locked, all_locked, cal_en, es);
      end
      set_ch(0, 1, t % WINDOW);
      set_ch(1, 4, 0);
      set_ch(2, 1, t % WINDOW);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_scn3_run_len();
    int n, p;
    logic [2:0][3:0] es;
    restart();
    for (int t = 0; t < 360; t++) begin
      n = (t >= 64) + (t >= 136) + (t >= 208);
      es = '{4'(n), 4'(n), 4'(n)};
      vectors++;
      if (bitslip !== ((t == 64 || t == 136 || t == 208) ? 3'b111 : 3'b000) || slip_cnt !== es
          || locked !== (t >= 344 ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL scn3 t=%0d got bs=%b sc=%h lk=%b exp sc=%h lk=%0d", t, bitslip, slip_cnt, locked, es, t >= 344);
      end
      p = t < 3 * PER ? t % PER : (t - 3 * PER) % WINDOW;
      for (int c = 0; c < 3; c++) set_ch(c, t < 3 * PER ? 2 : 1, p);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_scn4_unlock();
    logic plan [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    restart();
    for (int t = 0; t < 448; t++) begin
      vectors++;
      if (locked !== ((t >= 128 && t < 384) ? 3'b111 : 3'b000) || bitslip !== 3'b000 || cal_en !== !(t >= 129 && t <= 384)) begin
        errors++;
        $display("FAIL scn4 t=%0d got lk=%b bs=%b ce=%b", t, locked, bitslip, cal_en);
      end
      for (int c = 0; c < 3; c++) set_ch(c, plan[t / WINDOW] ? 1 : 0, t % WINDOW);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_scn5_disable();
    int d;
    d = $urandom_range(64, 71);
    restart();
    for (int t = 0; t <= d; t++) begin
      vectors++;
      if (bitslip !== (t == 64 ? 3'b111 : 3'b000) || slip_cnt !== (t >= 64 ? 12'h111 : 12'h000)) begin
        errors++;
        $display("FAIL scn5 t=%0d got bs=%b sc=%h", t, bitslip, slip_cnt);
      end
      for (int c = 0; c < 3; c++) set_ch(c, 0, 0);
      if (t == d) en = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bitslip, locked, all_locked, cal_en} !== 8'd0 || slip_cnt !== 12'd0) begin
        errors++;
        $display("FAIL scn5_idle i=%0d got bs=%b lk=%b ce=%b sc=%h exp all zero", i, bitslip, locked, cal_en, slip_cnt);
      end
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t <= 64; t++) begin
      vectors++;
      if (bitslip !== (t == 64 ? 3'b111 : 3'b000) || slip_cnt !== (t >= 64 ? 12'h111 : 12'h000)) begin
        errors++;
        $display("FAIL scn5_restart t=%0d got bs=%b sc=%h", t, bitslip, slip_cnt);
      end
      for (int c = 0; c < 3; c++) set_ch(c, 0, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_scn6_async_reset();
    int r;
    r = $urandom_range(5, 40);
    restart();
    for (int t = 0; t < 128 + r; t++) begin
      for (int c = 0; c < 3; c++) set_ch(c, 1, t % WINDOW);
      @(posedge clk);
      #1;
    end
    vectors++;
    if (locked !== 3'b111) begin
      errors++;
      $display("FAIL scn6_prelock got lk=%b exp 111", locked);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bitslip, locked, all_locked, cal_en} !== 8'd0 || slip_cnt !== 12'd0) begin
      errors++;
      $display("FAIL scn6_async got bs=%b lk=%b al=%b ce=%b sc=%h exp all zero", bitslip, locked, all_locked, cal_en, slip_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int t = 0; t < 130; t++) begin
      vectors++;
      if (locked !== (t >= 128 ? 3'b111 : 3'b000) || bitslip !== 3'b000) begin
        errors++;
        $display("FAIL scn6_resume t=%0d got lk=%b bs=%b", t, locked, bitslip);
      end
      for (int c = 0; c < 3; c++) set_ch(c, 1, t % WINDOW);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] m, el, eb;
    logic [2:0][3:0] es;
    int n;
    for (int it = 0; it < 3; it++) begin
      m = 3'($urandom_range(0, 7));
      restart();
      for (int t = 0; t < 300; t++) begin
        n = t < WINDOW ? 0 : ((t - WINDOW) / PER + 1) % 10;
        for (int c = 0; c < 3; c++) begin
          el[c] = !m[c] && t >= 128;
          eb[c] = m[c] && t >= WINDOW && (t - WINDOW) % PER == 0;
          es[c] = m[c] ? 4'(n) : 4'd0;
        end
        vectors++;
        if (locked !== el || bitslip !== eb || slip_cnt !== es || all_locked !== (el == 3'b111) || cal_en !== !(m == 3'b000 && t >= 129)) begin
          errors++;
          $display("FAIL b2b m=%b t=%0d got lk=%b bs=%b sc=%h ce=%b exp lk=%b bs=%b sc=%h", m, t, locked, bitslip, slip_cnt, cal_en, el, eb, es);
        end
        for (int c = 0; c < 3; c++) set_ch(c, m[c] ? 0 : 1, t % WINDOW);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scn1_lock();
    test_scn2_noise();
    test_scn3_run_len();
    test_scn4_unlock();
    test_scn5_disable();
    test_scn6_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
